// File: rtl/token_crc_ctrl.sv
// Framed USB token CRC5 checker: collects the 16-bit token field bit by bit, captures
// address/endpoint and reports good/CRC-bad/length-bad once per packet at EOP.
module token_crc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bitValid,
  input  logic       bitIn,
  input  logic       eop,
  output logic       busy,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic       tokenValid,
  output logic       crcError,
  output logic       lengthError
);

  localparam logic [4:0] CrcInit    = 5'b11111;
  localparam logic [4:0] CrcPoly    = 5'b00101;
  localparam logic [4:0] CrcResidue = 5'b01100;
  localparam logic [4:0] FieldBits  = 5'd16;

  typedef enum logic [1:0] {StIdle, StField, StWaitEop, StReport} state_e;
  typedef enum logic [1:0] {ResNone, ResOk, ResCrc, ResLen} res_e;

  state_e     state_q, state_d;
  res_e       res_q, res_d;
  logic [4:0] crc_q, crc_d;
  logic [4:0] count_q, count_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic       extra_q, extra_d;

  logic       fb;
  logic [4:0] crc_next;

  assign fb       = bitIn ^ crc_q[4];
  assign crc_next = {crc_q[3:0], 1'b0} ^ (fb ? CrcPoly : 5'b00000);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    crc_d   = crc_q;
    count_d = count_q;
    addr_d  = addr_q;
    endp_d  = endp_q;
    extra_d = extra_q;

    // start wins from any state, including REPORT, and silently drops the old packet
    if (start) begin
      state_d = StField;
      res_d   = ResNone;
      crc_d   = CrcInit;
      count_d = 5'd0;
      addr_d  = 7'd0;
      endp_d  = 4'd0;
      extra_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StField: begin
          if (eop) begin
            state_d = StReport;
            res_d   = ResLen;
          end else if (bitValid) begin
            crc_d = crc_next;
            if (count_q < 5'd7) begin
              addr_d = {bitIn, addr_q[6:1]};
            end else if (count_q < 5'd11) begin
              endp_d = {bitIn, endp_q[3:1]};
            end
            count_d = (count_q == FieldBits) ? count_q : count_q + 5'd1;
            if (count_q == FieldBits - 5'd1) begin
              state_d = StWaitEop;
            end
          end
        end
        StWaitEop: begin
          if (eop) begin
            state_d = StReport;
            if (extra_q) begin
              res_d = ResLen;
            end else if (crc_q == CrcResidue) begin
              res_d = ResOk;
            end else begin
              res_d = ResCrc;
            end
          end else if (bitValid) begin
            extra_d = 1'b1;
          end
        end
        StReport: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= ResNone;
      crc_q   <= CrcInit;
      count_q <= 5'd0;
      addr_q  <= 7'd0;
      endp_q  <= 4'd0;
      extra_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      extra_q <= extra_d;
    end
  end

  assign busy        = (state_q == StField) || (state_q == StWaitEop);
  assign addr        = addr_q;
  assign endp        = endp_q;
  assign tokenValid  = (state_q == StReport) && (res_q == ResOk);
  assign crcError    = (state_q == StReport) && (res_q == ResCrc);
  assign lengthError = (state_q == StReport) && (res_q == ResLen);

endmodule

// File: tb/tb_token_crc_ctrl.sv
// Directed bench for token_crc_ctrl: good, corrupted, short/long, gapped, aborted and
// reset-interrupted token packets.
module tb_token_crc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       bitValid;
  logic       bitIn;
  logic       eop;
  logic       busy;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       tokenValid;
  logic       crcError;
  logic       lengthError;

  int total = 0;
  int bad   = 0;
  int n_tok = 0;
  int n_crc = 0;
  int n_len = 0;

  always #5 clk = ~clk;

  token_crc_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bitValid    (bitValid),
    .bitIn       (bitIn),
    .eop         (eop),
    .busy        (busy),
    .addr        (addr),
    .endp        (endp),
    .tokenValid  (tokenValid),
    .crcError    (crcError),
    .lengthError (lengthError)
  );

  // Pulse tally, sampled mid-cycle
  always @(posedge clk) begin
    #2;
    if (tokenValid)  n_tok++;
    if (crcError)    n_crc++;
    if (lengthError) n_len++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bitValid = 1'b1;
    bitIn    = b;
    step();
    bitValid = 1'b0;
    bitIn    = 1'b0;
    repeat (gap) step();
  endtask

  // Token field: addr and endp LSB first, then the CRC5 field high bit first
  task automatic send_token(input logic [6:0] a, input logic [3:0] e, input logic [4:0] c,
                            input int nbits, input bit gapped);
    logic [15:0] pkt;
    pkt[6:0]  = a;
    pkt[10:7] = e;
    for (int i = 0; i < 5; i++) pkt[11+i] = c[4-i];
    for (int i = 0; i < nbits; i++) begin
      send_bit(pkt[i % 16], gapped ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  // exp = {lengthError, crcError, tokenValid}
  task automatic end_packet(input string tag, input bit with_bit, input logic [2:0] exp);
    check({tag, "_pre_pulse"}, {29'd0, lengthError, crcError, tokenValid}, 32'd0);
    eop      = 1'b1;
    bitValid = with_bit;
    bitIn    = 1'b1;
    step();
    eop      = 1'b0;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    check({tag, "_pulse"}, {29'd0, lengthError, crcError, tokenValid}, {29'd0, exp});
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    step();
    check({tag, "_one_cycle"}, {29'd0, lengthError, crcError, tokenValid}, 32'd0);
  endtask

  initial begin
    int tok0;
    rst      = 1'b1;
    start    = 1'b0;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    eop      = 1'b0;
    repeat (3) step();
    check("rst_outputs", {19'd0, busy, addr, endp, tokenValid, crcError, lengthError}, 32'd0);
    rst = 1'b0;
    step();

    // Good token: addr 15h, endp Eh, CRC5 17h
    do_start();
    check("good_busy", {31'd0, busy}, 32'd1);
    send_token(7'h15, 4'hE, 5'b10111, 16, 1'b0);
    check("good_busy_wait", {31'd0, busy}, 32'd1);
    end_packet("good", 1'b0, 3'b001);
    check("good_addr", {25'd0, addr}, 32'h15);
    check("good_endp", {28'd0, endp}, 32'hE);

    // Same CRC field but address bit 3 flipped
    do_start();
    send_token(7'h1D, 4'hE, 5'b10111, 16, 1'b0);
    end_packet("badcrc", 1'b0, 3'b010);
    check("badcrc_addr", {25'd0, addr}, 32'h1D);

    // Short and long packets
    do_start();
    send_token(7'h15, 4'hE, 5'b10111, 12, 1'b0);
    end_packet("short", 1'b0, 3'b100);
    do_start();
    send_token(7'h15, 4'hE, 5'b10111, 17, 1'b0);
    end_packet("long", 1'b0, 3'b100);

    // Gapped strobes and a bit coinciding with eop that must be ignored
    do_start();
    send_token(7'h3A, 4'hA, 5'b11100, 16, 1'b1);
    end_packet("gapped", 1'b1, 3'b001);
    check("gapped_addr", {25'd0, addr}, 32'h3A);
    check("gapped_endp", {28'd0, endp}, 32'hA);

    // eop together with the 16th bit: bit dropped, packet short
    do_start();
    send_token(7'h15, 4'hE, 5'b10111, 15, 1'b0);
    end_packet("eop_bit16", 1'b1, 3'b100);

    // Abort after 8 bits, then a complete good packet
    tok0 = n_tok;
    do_start();
    send_token(7'h15, 4'hE, 5'b10111, 8, 1'b0);
    do_start();
    check("abort_addr_clr", {21'd0, addr, endp}, 32'd0);
    send_token(7'h3A, 4'hA, 5'b11100, 16, 1'b0);
    end_packet("abort", 1'b0, 3'b001);
    check("abort_tok_count", n_tok - tok0, 32'd1);

    // Reset at bit 10, then a lone eop must produce nothing
    do_start();
    send_token(7'h15, 4'hE, 5'b10111, 10, 1'b0);
    check("rst_mid_addr_pre", {25'd0, addr}, 32'h15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outputs", {19'd0, busy, addr, endp, tokenValid, crcError, lengthError},
          32'd0);
    end_packet("rst_eop", 1'b0, 3'b000);

    check("tally_tok", n_tok, 32'd3);
    check("tally_crc", n_crc, 32'd1);
    check("tally_len", n_len, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
